// File: rtl/traffic_pkg.sv
// Shared state codes, lamp encodings and helpers for the intersection controller.
package traffic_pkg;

  localparam logic [2:0] ST_ALL_RED = 3'd0;
  localparam logic [2:0] ST_NS_G    = 3'd1;
  localparam logic [2:0] ST_NS_Y    = 3'd2;
  localparam logic [2:0] ST_EW_G    = 3'd3;
  localparam logic [2:0] ST_EW_Y    = 3'd4;
  localparam logic [2:0] ST_WALK    = 3'd5;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  typedef enum logic {DIR_NS = 1'b0, DIR_EW = 1'b1} dir_t;

  localparam int TIMER_W_DEFAULT = $clog2(8 + 1);

  function automatic int timer_w(input int green_max);
    return $clog2(green_max + 1);
  endfunction

  function automatic logic [2:0] ns_lamp(input logic [2:0] st);
    case (st)
      ST_NS_G: return LIGHT_GRN;
      ST_NS_Y: return LIGHT_YEL;
      default: return LIGHT_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(input logic [2:0] st);
    case (st)
      ST_EW_G: return LIGHT_GRN;
      ST_EW_Y: return LIGHT_YEL;
      default: return LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/intersection_controller_if.sv
// Sensor/button inputs and lamp-driver outputs of the intersection controller.
interface intersection_controller_if;
  logic       tick;
  logic       ew_car;
  logic       ped_btn;
  logic [2:0] ns_lights;
  logic [2:0] ew_lights;
  logic       walk;
  logic       ped_wait;
  logic [2:0] phase;

  modport master (
    output tick, ew_car, ped_btn,
    input  ns_lights, ew_lights, walk, ped_wait, phase
  );

  modport slave (
    input  tick, ew_car, ped_btn,
    output ns_lights, ew_lights, walk, ped_wait, phase
  );
endinterface

// File: rtl/phase_timer.sv
// Tick-enabled saturating up-counter, cleared whenever the controller changes state.
module phase_timer #(
  parameter int CNT_W = 4,
  parameter int SAT   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] C_SAT = CNT_W'(SAT);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over counting: the entry edge is itself a tick edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_tick && (r_cnt != C_SAT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/intersection_controller.sv
// Two-road intersection sequencer with latched pedestrian walk phase.
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALL_RED_T = 1,
  parameter int WALK_T    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  intersection_controller_if.slave  bus
);

  localparam int CNT_W = timer_w(GREEN_MAX);

  localparam logic [CNT_W-1:0] C_GMIN = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] C_GMAX = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] C_YEL  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] C_AR   = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] C_WALK = CNT_W'(WALK_T - 1);

  logic [2:0]       r_state, r_next;
  dir_t             r_last;
  logic             r_ped;
  logic [2:0]       r_ns, r_ew, r_phase;
  logic             r_walk;
  logic [CNT_W-1:0] w_cnt;
  logic [2:0]       w_state_d, w_next_d;
  dir_t             w_last_d;
  logic             w_enter;
  logic             w_tick;

  assign w_tick = bus.tick;

  always_comb begin
    w_state_d = r_state;
    w_next_d  = r_next;
    w_last_d  = r_last;
    case (r_state)
      ST_ALL_RED: if (w_tick && w_cnt == C_AR) w_state_d = r_next;
      ST_NS_G: begin
        if (w_tick && w_cnt >= C_GMIN && (bus.ew_car || r_ped)) w_state_d = ST_NS_Y;
      end
      ST_NS_Y: begin
        if (w_tick && w_cnt == C_YEL) begin
          w_state_d = ST_ALL_RED;
          w_last_d  = DIR_NS;
          w_next_d  = r_ped ? ST_WALK : ST_EW_G;
        end
      end
      // EW green is capped even while cars keep arriving.
      ST_EW_G: begin
        if (w_tick && (w_cnt >= C_GMAX ||
                       (w_cnt >= C_GMIN && (!bus.ew_car || r_ped)))) begin
          w_state_d = ST_EW_Y;
        end
      end
      ST_EW_Y: begin
        if (w_tick && w_cnt == C_YEL) begin
          w_state_d = ST_ALL_RED;
          w_last_d  = DIR_EW;
          w_next_d  = r_ped ? ST_WALK : ST_NS_G;
        end
      end
      ST_WALK: begin
        if (w_tick && w_cnt == C_WALK) begin
          w_state_d = ST_ALL_RED;
          w_next_d  = (r_last == DIR_NS && bus.ew_car) ? ST_EW_G : ST_NS_G;
        end
      end
      default: w_state_d = ST_ALL_RED;
    endcase
  end

  assign w_enter = (w_state_d != r_state);

  phase_timer #(
    .CNT_W (CNT_W),
    .SAT   (GREEN_MAX)
  ) u_timer (
    .clk    (clk),
    .rst_n  (reset),
    .i_tick (w_tick),
    .i_clr  (w_enter),
    .o_cnt  (w_cnt)
  );

  // Lamps are decoded from the next state so they switch on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_ALL_RED;
      r_next  <= ST_NS_G;
      r_last  <= DIR_EW;
      r_ped   <= 1'b0;
      r_ns    <= LIGHT_RED;
      r_ew    <= LIGHT_RED;
      r_walk  <= 1'b0;
      r_phase <= ST_ALL_RED;
    end else begin
      r_state <= w_state_d;
      r_next  <= w_next_d;
      r_last  <= w_last_d;
      r_ped   <= (w_state_d == ST_WALK || r_state == ST_WALK) ? 1'b0
                                                               : (r_ped | bus.ped_btn);
      r_ns    <= ns_lamp(w_state_d);
      r_ew    <= ew_lamp(w_state_d);
      r_walk  <= (w_state_d == ST_WALK);
      r_phase <= w_state_d;
    end
  end

  assign bus.ns_lights = r_ns;
  assign bus.ew_lights = r_ew;
  assign bus.walk      = r_walk;
  assign bus.ped_wait  = r_ped;
  assign bus.phase     = r_phase;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller: phase sequences, lamps, walk and pedestrian latch.
module tb_intersection_controller;

  localparam logic [2:0] P_AR  = 3'd0;
  localparam logic [2:0] P_NSG = 3'd1;
  localparam logic [2:0] P_NSY = 3'd2;
  localparam logic [2:0] P_EWG = 3'd3;
  localparam logic [2:0] P_EWY = 3'd4;
  localparam logic [2:0] P_WLK = 3'd5;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   div = 1;

  always #5 clk = ~clk;

  intersection_controller_if bus ();

  intersection_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [2:0] exp_ns(input logic [2:0] ph);
    case (ph)
      P_NSG:   return 3'b001;
      P_NSY:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_ew(input logic [2:0] ph);
    case (ph)
      P_EWG:   return 3'b001;
      P_EWY:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.tick = (div == 1) || (cyc % div == 0);
  endtask

  task automatic chk_now(input string tag, input logic [2:0] ph, input logic pw);
    chk({tag, ".phase"}, 8'(bus.phase), 8'(ph));
    chk({tag, ".ns"}, 8'(bus.ns_lights), 8'(exp_ns(ph)));
    chk({tag, ".ew"}, 8'(bus.ew_lights), 8'(exp_ew(ph)));
    chk({tag, ".walk"}, 8'(bus.walk), 8'(ph == P_WLK));
    chk({tag, ".ped_wait"}, 8'(bus.ped_wait), 8'(pw));
    chk({tag, ".safe"}, 8'(bus.ns_lights != 3'b100 && bus.ew_lights != 3'b100), 8'd0);
  endtask

  task automatic expect_seq(input logic [2:0] ph, input int n, input logic pw, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      chk_now(tag, ph, pw);
    end
  endtask

  task automatic do_reset(input logic car, input string tag);
    reset       = 1'b0;
    bus.ew_car  = car;
    bus.ped_btn = 1'b0;
    bus.tick    = 1'b1;
    @(posedge clk);
    #1;
    chk_now({tag, ".rst"}, P_AR, 1'b0);
    @(posedge clk);
    #1;
    cyc      = 0;
    bus.tick = 1'b1;
    reset    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    bus.tick    = 1'b1;
    bus.ew_car  = 1'b0;
    bus.ped_btn = 1'b0;

    // Test 1: no demand, NS rests green.
    div = 1;
    do_reset(1'b0, "t1");
    expect_seq(P_NSG, 55, 1'b0, "t1");

    // Test 2: continuous EW demand, EW green runs to its maximum.
    do_reset(1'b1, "t2");
    expect_seq(P_NSG, 4, 1'b0, "t2");
    expect_seq(P_NSY, 2, 1'b0, "t2");
    expect_seq(P_AR,  1, 1'b0, "t2");
    expect_seq(P_EWG, 8, 1'b0, "t2");
    expect_seq(P_EWY, 2, 1'b0, "t2");
    expect_seq(P_AR,  1, 1'b0, "t2");
    expect_seq(P_NSG, 4, 1'b0, "t2");
    expect_seq(P_NSY, 1, 1'b0, "t2");

    // Test 3: EW demand drops early, EW green ends at the minimum.
    do_reset(1'b1, "t3");
    expect_seq(P_NSG, 4, 1'b0, "t3");
    expect_seq(P_NSY, 2, 1'b0, "t3");
    expect_seq(P_AR,  1, 1'b0, "t3");
    expect_seq(P_EWG, 2, 1'b0, "t3");
    bus.ew_car = 1'b0;
    expect_seq(P_EWG, 2, 1'b0, "t3");
    expect_seq(P_EWY, 2, 1'b0, "t3");
    expect_seq(P_AR,  1, 1'b0, "t3");
    expect_seq(P_NSG, 10, 1'b0, "t3");

    // Test 4: pedestrian pulse during NS green; presses during WALK are dropped.
    do_reset(1'b0, "t4");
    expect_seq(P_NSG, 6, 1'b0, "t4");
    bus.ped_btn = 1'b1;
    expect_seq(P_NSG, 1, 1'b1, "t4");
    bus.ped_btn = 1'b0;
    expect_seq(P_NSY, 2, 1'b1, "t4");
    expect_seq(P_AR,  1, 1'b1, "t4");
    expect_seq(P_WLK, 1, 1'b0, "t4");
    bus.ped_btn = 1'b1;
    expect_seq(P_WLK, 1, 1'b0, "t4");
    bus.ped_btn = 1'b0;
    expect_seq(P_WLK, 1, 1'b0, "t4");
    expect_seq(P_AR,  1, 1'b0, "t4");
    expect_seq(P_NSG, 6, 1'b0, "t4");

    // Test 5: tick every 4th cycle scales every duration by four.
    div = 4;
    do_reset(1'b1, "t5");
    expect_seq(P_NSG, 16, 1'b0, "t5");
    expect_seq(P_NSY, 8,  1'b0, "t5");
    expect_seq(P_AR,  4,  1'b0, "t5");
    expect_seq(P_EWG, 32, 1'b0, "t5");
    expect_seq(P_EWY, 8,  1'b0, "t5");
    expect_seq(P_AR,  4,  1'b0, "t5");
    expect_seq(P_NSG, 16, 1'b0, "t5");
    expect_seq(P_NSY, 1,  1'b0, "t5");

    // Test 6: asynchronous reset in the middle of EW green.
    div = 1;
    do_reset(1'b1, "t6");
    expect_seq(P_NSG, 4, 1'b0, "t6");
    expect_seq(P_NSY, 2, 1'b0, "t6");
    expect_seq(P_AR,  1, 1'b0, "t6");
    expect_seq(P_EWG, 3, 1'b0, "t6");
    #2;
    reset = 1'b0;
    #1;
    chk_now("t6.async", P_AR, 1'b0);
    @(posedge clk);
    #1;
    chk_now("t6.held", P_AR, 1'b0);
    cyc      = 0;
    bus.tick = 1'b1;
    reset    = 1'b1;
    expect_seq(P_NSG, 4, 1'b0, "t6.post");
    expect_seq(P_NSY, 1, 1'b0, "t6.post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
